coram_memory_arbiter: RTL

CORAM_MEMORY_ARBITER -- requirements
Module: coram_memory_arbiter

---
 rtl/coram_arb_pkg.sv | 20 ++
 rtl/coram_arb_rdtag.sv | 73 +++++++
 rtl/coram_memory_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/coram_arb_pkg.sv
// Shared types and constants for the two-requester CoRAM port arbiter.
// Build option: CORAM_ARB_QDATA_REG_EN adds an output register on read returns (latency 2).
package coram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int BCNT_W = 8;
    localparam logic [BCNT_W-1:0] BCNT_SAT = '1;

`ifdef CORAM_ARB_QDATA_REG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/coram_arb_rdtag.sv
// Tracks which requester owns the read returning from the 1-cycle memory and
// steers MEM_Q to that requester's QDATA/QVALID, holding QDATA between returns.
module coram_arb_rdtag
    import coram_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   rd_issue,
    input  logic                   rd_tag,
    input  logic [DATA_W-1:0]      mem_q,
    output logic [1:0]             qvalid,
    output logic [1:0][DATA_W-1:0] qdata
);

    logic rd_valid_reg;
    logic rd_tag_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_valid_reg <= 1'b0;
            rd_tag_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_issue;
            rd_tag_reg   <= rd_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic ret_hit;
            // MEM_Q carries this requester's read data in the current cycle
            assign ret_hit = rd_valid_reg && ((gi == 1) ? rd_tag_reg : !rd_tag_reg);

            if (RD_LATENCY == 1) begin : g_direct
                logic [DATA_W-1:0] hold_reg;

                always_ff @(posedge clk) begin
                    if (srst) begin
                        hold_reg <= '0;
                    end else if (ret_hit) begin
                        hold_reg <= mem_q;
                    end
                end

                // Reset masks a return already in the pipe during the reset cycle itself
                assign qvalid[gi] = ret_hit && !srst;
                assign qdata[gi]  = srst ? '0 : (ret_hit ? mem_q : hold_reg);
            end else begin : g_registered
                logic              qvalid_reg;
                logic [DATA_W-1:0] qdata_reg;

                always_ff @(posedge clk) begin
                    if (srst) begin
                        qvalid_reg <= 1'b0;
                        qdata_reg  <= '0;
                    end else begin
                        qvalid_reg <= ret_hit;
                        if (ret_hit) begin
                            qdata_reg <= mem_q;
                        end
                    end
                end

                assign qvalid[gi] = qvalid_reg && !srst;
                assign qdata[gi]  = srst ? '0 : qdata_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/coram_memory_arbiter.sv
// Two-requester arbiter for a single-port CoRAM with bounded bursts and round-robin tie break.
// Build option: CORAM_ARB_QDATA_REG_EN registers read returns (read latency 2 instead of 1).
module coram_memory_arbiter
    import coram_arb_pkg::*;
#(
    parameter int CORAM_ADDR_LEN   = 10,
    parameter int CORAM_DATA_WIDTH = 32,
    parameter int MAX_BURST        = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        REQ0,
    input  logic [CORAM_ADDR_LEN-1:0]   ADDR0,
    input  logic [CORAM_DATA_WIDTH-1:0] D0,
    input  logic                        WE0,
    output logic                        GNT0,
    output logic                        QVALID0,
    output logic [CORAM_DATA_WIDTH-1:0] QDATA0,
    input  logic                        REQ1,
    input  logic [CORAM_ADDR_LEN-1:0]   ADDR1,
    input  logic [CORAM_DATA_WIDTH-1:0] D1,
    input  logic                        WE1,
    output logic                        GNT1,
    output logic                        QVALID1,
    output logic [CORAM_DATA_WIDTH-1:0] QDATA1,
    output logic [CORAM_ADDR_LEN-1:0]   MEM_ADDR,
    output logic [CORAM_DATA_WIDTH-1:0] MEM_D,
    output logic                        MEM_WE,
    input  logic [CORAM_DATA_WIDTH-1:0] MEM_Q
);

    localparam logic [BCNT_W-1:0] BURST_LIM = MAX_BURST[BCNT_W-1:0];

    arb_state_t        state_reg;
    logic [BCNT_W-1:0] bcnt_reg;
    logic              prio_reg;

    logic grant_any;
    logic grant_sel;
    logic own_sel;
    logic own_req;
    logic oth_req;
    logic we_sel;

    always_comb begin
        own_sel   = (state_reg == OWN1);
        own_req   = own_sel ? REQ1 : REQ0;
        oth_req   = own_sel ? REQ0 : REQ1;
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (!RST) begin
            case (state_reg)
                IDLE: begin
                    if (REQ0 && REQ1) begin
                        grant_any = 1'b1;
                        grant_sel = prio_reg;
                    end else if (REQ0 || REQ1) begin
                        grant_any = 1'b1;
                        grant_sel = REQ1;
                    end
                end
                OWN0, OWN1: begin
                    // Owner keeps the port until its burst quota runs out with the other side waiting
                    if (own_req && ((bcnt_reg < BURST_LIM) || !oth_req)) begin
                        grant_any = 1'b1;
                        grant_sel = own_sel;
                    end else if (oth_req) begin
                        grant_any = 1'b1;
                        grant_sel = !own_sel;
                    end
                end
                default: begin
                    grant_any = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            bcnt_reg  <= '0;
            prio_reg  <= 1'b0;
        end else if (!grant_any) begin
            state_reg <= IDLE;
            bcnt_reg  <= '0;
        end else if ((state_reg != IDLE) && (grant_sel == own_sel)) begin
            if (bcnt_reg != BCNT_SAT) begin
                bcnt_reg <= bcnt_reg + 8'd1;
            end
        end else begin
            state_reg <= grant_sel ? OWN1 : OWN0;
            bcnt_reg  <= 8'd1;
            prio_reg  <= !grant_sel;
        end
    end

    assign we_sel   = grant_sel ? WE1 : WE0;
    assign GNT0     = grant_any && !grant_sel;
    assign GNT1     = grant_any && grant_sel;
    assign MEM_ADDR = grant_sel ? ADDR1 : ADDR0;
    assign MEM_D    = grant_sel ? D1 : D0;
    assign MEM_WE   = grant_any && we_sel;

    logic [1:0]                       qvalid_w;
    logic [1:0][CORAM_DATA_WIDTH-1:0] qdata_w;

    coram_arb_rdtag #(
        .DATA_W (CORAM_DATA_WIDTH)
    ) u_rdtag (
        .clk      (CLK),
        .srst     (RST),
        .rd_issue (grant_any && !we_sel),
        .rd_tag   (grant_sel),
        .mem_q    (MEM_Q),
        .qvalid   (qvalid_w),
        .qdata    (qdata_w)
    );

    assign QVALID0 = qvalid_w[0];
    assign QVALID1 = qvalid_w[1];
    assign QDATA0  = qdata_w[0];
    assign QDATA1  = qdata_w[1];

endmodule
